ucode_sequencer: RTL and testbench

- Drives the micro-code entry/exit sequence around the shadow-register file: raises ucode_flag, waits for the shadow copy to settle, steps a micro-op ROM address, drains in-flight writes, then returns the core to regular mode.
- Sits between decode (start/abort), the micro-op ROM (rom_addr/rom_last) and the register file (ucode_flag).
- Asserts busy to stall fetch for the whole sequence.

---
 rtl/ucode_sequencer.sv | 134 +++++++++++++
 tb/tb_ucode_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - micro-code entry/exit sequencer around the shadow-register file
module ucode_sequencer #(
  parameter int UADDR_W   = 8,
  parameter int ENTER_CYC = 2,
  parameter int DRAIN_CYC = 3,
  parameter int MAX_UOPS  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [UADDR_W-1:0] entry_addr,
  input  logic               rom_last,
  input  logic               uop_ready,
  input  logic               abort,
  output logic               ucode_flag,
  output logic               busy,
  output logic [UADDR_W-1:0] rom_addr,
  output logic               uop_valid,
  output logic               done,
  output logic               err
);

  localparam int MAX_CYC = (ENTER_CYC > DRAIN_CYC) ? ENTER_CYC : DRAIN_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int UW      = $clog2(MAX_UOPS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ENTER, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [UW-1:0]      r_uops;
  logic               r_flag;
  logic               r_busy;
  logic               r_valid;
  logic               r_done;
  logic               r_err;
  logic [UADDR_W-1:0] r_addr;

  logic               w_accept;
  logic [UW-1:0]      w_uops_next;

  assign w_accept    = r_valid && uop_ready;
  assign w_uops_next = r_uops + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_uops  <= '0;
      r_flag  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // abort outranks everything once a sequence is under way, including an accept
      if (r_state != S_IDLE && abort) begin
        r_state <= S_IDLE;
        r_flag  <= 1'b0;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
        r_addr  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_state <= S_ENTER;
              r_addr  <= entry_addr;
              r_cnt   <= CW'(ENTER_CYC - 1);
              r_uops  <= '0;
              r_flag  <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_ENTER: begin
            if (r_cnt == '0) begin
              r_state <= S_RUN;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_RUN: begin
            if (w_accept) begin
              if (rom_last) begin
                r_state <= S_DRAIN;
                r_valid <= 1'b0;
                r_cnt   <= CW'(DRAIN_CYC - 1);
              end else if (w_uops_next == UW'(MAX_UOPS)) begin
                // runaway micro-program: bail out without a done
                r_state <= S_IDLE;
                r_flag  <= 1'b0;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_addr  <= '0;
                r_err   <= 1'b1;
              end else begin
                r_addr <= r_addr + 1'b1;
                r_uops <= w_uops_next;
              end
            end
          end
          S_DRAIN: begin
            if (r_cnt == '0) begin
              r_state <= S_DONE;
              r_flag  <= 1'b0;
              r_busy  <= 1'b0;
              r_addr  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DONE: begin
            // one extra low cycle so the flag is low for two cycles between sequences
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ucode_flag = r_flag;
  assign busy       = r_busy;
  assign rom_addr   = r_addr;
  assign uop_valid  = r_valid;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb/tb_ucode_sequencer.sv - directed self-checking bench for ucode_sequencer
module tb_ucode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       uop_ready = 1'b0;
  logic [7:0] entry_addr = 8'h00;
  logic [7:0] last_addr = 8'h00;
  logic       last_en = 1'b0;
  logic       rom_last;
  logic       ucode_flag, busy, uop_valid, done, err;
  logic [7:0] rom_addr;

  int n_cmp = 0;
  int n_err = 0;
  int flag_cyc, busy_cyc, valid_cyc, done_cnt, err_cnt;
  logic [7:0] acc_q[$];

  always #5 clk = ~clk;

  assign rom_last = last_en && (rom_addr == last_addr);

  ucode_sequencer #(
    .UADDR_W(8), .ENTER_CYC(2), .DRAIN_CYC(3), .MAX_UOPS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .entry_addr(entry_addr),
    .rom_last(rom_last), .uop_ready(uop_ready), .abort(abort),
    .ucode_flag(ucode_flag), .busy(busy), .rom_addr(rom_addr),
    .uop_valid(uop_valid), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; raises start for the next edge and watches a fixed window.
  task automatic run_seq(input logic [7:0] entry, input logic [7:0] last, input bit has_last,
                         input logic [7:0] stall_a, input int stall_n, input bit poke);
    int   stalls;
    logic prev_flag;
    flag_cyc = 0; busy_cyc = 0; valid_cyc = 0; done_cnt = 0; err_cnt = 0;
    acc_q.delete();
    stalls = stall_n;
    prev_flag = 1'b0;
    entry_addr = entry; last_addr = last; last_en = has_last;
    uop_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start = poke && uop_valid;
      if (uop_valid && rom_addr == stall_a && stalls > 0) begin
        uop_ready = 1'b0;
        stalls--;
      end else begin
        uop_ready = 1'b1;
      end
      if (uop_valid && uop_ready) acc_q.push_back(rom_addr);
      flag_cyc  += int'(ucode_flag);
      busy_cyc  += int'(busy);
      valid_cyc += int'(uop_valid);
      done_cnt  += int'(done);
      err_cnt   += int'(err);
      if (done) check("done_at_flag_fall", {30'd0, prev_flag, ucode_flag}, 32'h2);
      if (err) check("err_outs_low", {29'd0, ucode_flag, busy, uop_valid}, 32'h0);
      prev_flag = ucode_flag;
    end
    start = 1'b0;
    uop_ready = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [7:0] entry, input int n_acc,
                           input int flag_exp, input int valid_exp, input int done_exp,
                           input int err_exp);
    logic [7:0] a;
    check({tag, "_flag_cyc"}, flag_cyc, flag_exp);
    check({tag, "_busy_cyc"}, busy_cyc, flag_exp);
    check({tag, "_valid_cyc"}, valid_cyc, valid_exp);
    check({tag, "_done_cnt"}, done_cnt, done_exp);
    check({tag, "_err_cnt"}, err_cnt, err_exp);
    check({tag, "_n_accept"}, acc_q.size(), n_acc);
    for (int i = 0; i < acc_q.size() && i < n_acc; i++) begin
      a = entry + 8'(i);
      check($sformatf("%s_addr%0d", tag, i), acc_q[i], a);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {26'd0, ucode_flag, busy, uop_valid, done, err, 1'b0}, 32'h0);
    check("rst_addr", rom_addr, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // nominal: 0x10..0x12, flag 2+3+3
    run_seq(8'h10, 8'h12, 1'b1, 8'h00, 0, 1'b0);
    check_run("nominal", 8'h10, 3, 8, 3, 1, 0);

    // backpressure: two stall cycles at 0x11
    run_seq(8'h10, 8'h12, 1'b1, 8'h11, 2, 1'b0);
    check_run("stall", 8'h10, 3, 10, 5, 1, 0);

    // wrap through 0xFF with start poked during RUN
    run_seq(8'hFE, 8'h01, 1'b1, 8'h00, 0, 1'b1);
    check_run("wrap", 8'hFE, 4, 9, 4, 1, 0);

    // abort in the second RUN cycle, with uop_ready high
    entry_addr = 8'h10; last_addr = 8'h12; last_en = 1'b1; uop_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_run1_addr", {23'd0, uop_valid, rom_addr}, 32'h110);
    @(negedge clk);
    check("abort_run2_addr", {23'd0, uop_valid, rom_addr}, 32'h111);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outs", {27'd0, ucode_flag, busy, uop_valid, done, err}, 32'h0);
    check("abort_addr", rom_addr, 8'h00);
    @(negedge clk);
    check("abort_idle_done", {31'd0, done}, 32'h0);
    run_seq(8'h10, 8'h12, 1'b1, 8'h00, 0, 1'b0);
    check_run("post_abort", 8'h10, 3, 8, 3, 1, 0);

    // watchdog at 4 accepts with no last
    run_seq(8'h20, 8'h00, 1'b0, 8'h00, 0, 1'b0);
    check_run("wdog", 8'h20, 4, 6, 4, 0, 1);

    // reset during DRAIN
    entry_addr = 8'h10; last_addr = 8'h12; last_en = 1'b1; uop_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_drain", {30'd0, ucode_flag, uop_valid}, 32'h2);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {27'd0, ucode_flag, busy, uop_valid, done, err}, 32'h0);
    check("mid_rst_addr", rom_addr, 8'h00);
    rst = 1'b1;
    run_seq(8'h10, 8'h12, 1'b1, 8'h00, 0, 1'b0);
    check_run("post_rst", 8'h10, 3, 8, 3, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
